// File: rtl/led_flash_driver.sv
// Turns single-cycle event pulses into visible active-low LED flashes (ON_CYC lit, OFF_CYC dark),
// queueing events that arrive mid-flash in a saturating counter and replaying them back-to-back.
module led_flash_driver #(
  parameter int ON_CYC  = 2400000,
  parameter int OFF_CYC = 2400000,
  parameter int PEND_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              evt_pulse,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf,
  output logic [1:0]        state_dbg
);

  localparam int MAX_CYC = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
  localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYC - 1);
  localparam logic [TW-1:0]     OFF_LOAD = TW'(OFF_CYC - 1);
  localparam logic [TW-1:0]     T_ONE    = TW'(1);
  localparam logic [PEND_W-1:0] P_ONE    = PEND_W'(1);
  localparam logic [PEND_W-1:0] P_MAX    = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ON   = 2'd1;
  localparam logic [1:0] S_OFF  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_n;
  logic [TW-1:0]     timer;
  logic [TW-1:0]     timer_n;
  logic [PEND_W-1:0] pend_n;
  logic              ovf_n;
  logic              have_evt;
  logic              start;
  logic              from_q;
  logic              queue_evt;

  assign state_dbg = state;

  always_comb begin
    have_evt  = evt_pulse || (pend_cnt != '0);
    state_n   = state;
    timer_n   = timer;
    start     = 1'b0;
    case (state)
      S_IDLE: begin
        if (have_evt) start = 1'b1;
      end
      S_ON: begin
        if (timer == '0) begin
          state_n = S_OFF;
          timer_n = OFF_LOAD;
        end else begin
          timer_n = timer - T_ONE;
        end
      end
      S_OFF: begin
        if (timer == '0) begin
          if (have_evt) start = 1'b1;
          else          state_n = S_IDLE;
        end else begin
          timer_n = timer - T_ONE;
        end
      end
      default: begin
        state_n = S_IDLE;
        timer_n = '0;
      end
    endcase
    if (start) begin
      state_n = S_ON;
      timer_n = ON_LOAD;
    end

    // A starting flash takes from the queue first; the live pulse is then queued instead.
    from_q    = start && (pend_cnt != '0);
    queue_evt = evt_pulse && !(start && !from_q);

    pend_n = pend_cnt;
    ovf_n  = 1'b0;
    if (queue_evt && !from_q) begin
      if (pend_cnt == P_MAX) ovf_n  = 1'b1;
      else                   pend_n = pend_cnt + P_ONE;
    end else if (from_q && !queue_evt) begin
      pend_n = pend_cnt - P_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      timer    <= '0;
      pend_cnt <= '0;
      ovf      <= 1'b0;
      led      <= 1'b1;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pend_cnt <= pend_n;
      ovf      <= ovf_n;
      led      <= (state_n != S_ON);
      busy     <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_led_flash_driver.sv
// Randomized and directed bench for led_flash_driver; a flash-schedule model predicts
// {led,busy,pend_cnt,ovf} for each cycle and a monitor compares them against the DUT.
module tb_led_flash_driver;

  localparam int ON_CYC  = 4;
  localparam int OFF_CYC = 3;
  localparam int PEND_W  = 2;
  localparam int FLASH   = ON_CYC + OFF_CYC;
  localparam int PMAX    = (1 << PEND_W) - 1;

  logic              clk;
  logic              rst;
  logic              evt_pulse;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pend_cnt;
  logic              ovf;
  logic [1:0]        state_dbg;

  int checks   = 0;
  int failures = 0;

  // Expected outputs after each clocked edge: {led, busy, pend_cnt, ovf}
  logic [PEND_W+2:0] exp_q[$];

  // Model: a flash is active for FLASH cycles; m_off counts cycles since it started.
  bit m_active;
  int m_off;
  int m_pend;
  int ovf_seen;
  int flashes;

  led_flash_driver #(.ON_CYC(ON_CYC), .OFF_CYC(OFF_CYC), .PEND_W(PEND_W)) dut (
    .clk(clk), .rst(rst), .evt_pulse(evt_pulse), .led(led), .busy(busy),
    .pend_cnt(pend_cnt), .ovf(ovf), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0;
    m_off    = 0;
    m_pend   = 0;
  endtask

  task automatic model_step(input bit e);
    bit can_start;
    bit o;
    o = 0;
    can_start = !m_active || (m_off == FLASH - 1);
    if (can_start && (m_pend > 0 || e)) begin
      m_active = 1;
      m_off    = 0;
      flashes++;
      if (m_pend > 0 && !e) m_pend--;
    end else begin
      if (can_start) m_active = 0;
      else           m_off++;
      if (e) begin
        if (m_pend == PMAX) o = 1;
        else                m_pend++;
      end
    end
    if (o) ovf_seen++;
    exp_q.push_back({!(m_active && m_off < ON_CYC), m_active, PEND_W'(m_pend), o});
  endtask

  // driver tasks
  task automatic drive(input bit e);
    @(negedge clk);
    evt_pulse = e;
    model_step(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0);
  endtask

  task automatic drive_at_flash_end();
    int guard;
    guard = 0;
    while (!(m_active && m_off == FLASH - 1) && guard < 50) begin
      drive(1'b0);
      guard++;
    end
    check("reach_flash_end", guard < 50, 1);
    drive(1'b1);
  endtask

  task automatic reset_pulse(input int hold);
    @(negedge clk);
    evt_pulse = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_led", led, 1);
    check("rst_busy", busy, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_ovf", ovf, 0);
    model_reset();
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      evt_pulse = i[0];
      check("rst_hold_outputs", {led, busy, pend_cnt, ovf}, {1'b1, 1'b0, {PEND_W{1'b0}}, 1'b0});
    end
    @(negedge clk);
    evt_pulse = 1'b0;
    rst = 1'b1;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [PEND_W+2:0] exp_v;
    #1;
    if (exp_q.size() != 0) begin
      exp_v = exp_q.pop_front();
      check("outputs{led,busy,pend,ovf}", {led, busy, pend_cnt, ovf}, exp_v);
    end
  end

  initial begin
    int ovf_before;
    int flash_before;
    rst       = 1'b0;
    evt_pulse = 1'b0;
    flashes   = 0;
    ovf_seen  = 0;
    model_reset();

    // Reset held with toggling input, then quiet cycles after release
    reset_pulse(3);
    idle(5);

    // Single flash
    drive(1'b1);
    idle(10);

    // Three back-to-back pulses
    drive(1'b1); drive(1'b1); drive(1'b1);
    idle(25);

    // Overflow: five consecutive pulses
    ovf_before   = ovf_seen;
    flash_before = flashes;
    for (int i = 0; i < 5; i++) drive(1'b1);
    idle(35);
    check("ovf_pulse_count", ovf_seen - ovf_before, 1);
    check("overflow_flashes", flashes - flash_before, 4);

    // Coincidence (a): empty queue, pulse on final OFF cycle
    drive(1'b1);
    drive_at_flash_end();
    check("coinc_a_pend", m_pend, 0);
    idle(12);

    // Coincidence (b): full queue, pulse on final OFF cycle
    ovf_before = ovf_seen;
    for (int i = 0; i < 4; i++) drive(1'b1);
    drive_at_flash_end();
    check("coinc_b_no_ovf", ovf_seen - ovf_before, 0);
    idle(40);

    // Reset in cycle 2 of ON with two events queued
    drive(1'b1); drive(1'b1); drive(1'b1);
    reset_pulse(2);
    idle(10);

    // Randomized traffic with occasional mid-run reset
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse($urandom_range(1, 3));
      drive($urandom_range(0, 99) < 25);
    end
    idle(40);

    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_flash_driver.md
Name: led_flash_driver

Overview:
- Output-side counterpart to the key debounce path. The debouncer turns a noisy physical key into clean single-cycle pulses; this block turns clean single-cycle event pulses into human-visible LED flashes on the board's active-low LED pins.
- Each accepted event produces exactly one flash: ON for ON_CYC cycles, then OFF for OFF_CYC cycles.
- Events that arrive during a flash are queued in a saturating pending counter and replayed back-to-back.
- Sits between any pulse source (e.g. debounced key_pulse) and a top-level LED pin.

Parameters:
- ON_CYC, 2400000, lit duration in clk cycles (200 ms at 12 MHz); must be >= 1.
- OFF_CYC, 2400000, dark gap after each flash in clk cycles; must be >= 1.
- PEND_W, 4, width of the pending-event counter; maximum queue depth is 2^PEND_W-1.

Ports:
- clk  input  1  system clock (12 MHz on board).
- rst  input  1  reset, asynchronous, active-low.
- evt_pulse  input  1  event request; each cycle it is high counts as one event.
- led  output  1  LED drive, active-low (0 = lit, 1 = dark).
- busy  output  1  high while a flash (ON or OFF phase) is in progress.
- pend_cnt  output  PEND_W  number of queued events not yet started.
- ovf  output  1  single-cycle pulse when an event is dropped because the queue is full.

Behaviour:
- Reset (rst=0, asynchronous):
  - led=1, busy=0, pend_cnt=0, ovf=0, state=IDLE, timer=0.
  - Applies immediately, even mid-flash, and discards any queued events.
- State machine: IDLE, ON, OFF. All outputs are registered.
  - busy = (state != IDLE).
  - led = 0 only in ON.
- Timer:
  - Down-counter, width clog2(max(ON_CYC,OFF_CYC)) with a minimum of 1 bit.
  - Loaded with ON_CYC-1 on entry to ON and with OFF_CYC-1 on entry to OFF.
  - A phase ends on the cycle the timer reads 0.
- IDLE:
  - evt_pulse=1 sampled at edge E moves the FSM to ON at that edge.
  - led=0 and busy=1 are visible in the cycle after E.
  - pend_cnt is unchanged; the event is consumed directly.
- ON:
  - Lasts exactly ON_CYC cycles.
  - When timer==0, move to OFF.
- OFF:
  - Lasts exactly OFF_CYC cycles.
  - When timer==0 and pend_cnt>0 or evt_pulse=1: go directly to ON with no IDLE cycle. Consume one event, from the queue first if pend_cnt>0.
  - When timer==0 and no events are pending: go to IDLE.
- Queueing:
  - evt_pulse=1 in ON, or in OFF when it is not the consuming cycle, increments pend_cnt.
- Simultaneous events:
  - At the OFF end with pend_cnt>0 and evt_pulse=1: one queued event is consumed and the new event is queued, so pend_cnt is unchanged.
  - If the queue is saturated at that moment, the consume frees a slot, so no ovf is raised.
- Saturation:
  - When an increment is required and pend_cnt == 2^PEND_W-1, pend_cnt holds and ovf=1 for one cycle.
  - ovf is 0 in all other cycles.
- Invariant: in IDLE, pend_cnt==0.
  - If the invariant is violated, IDLE with pend_cnt>0 starts a flash and decrements pend_cnt. This is defensive only.
- Throughput: at most one flash per ON_CYC+OFF_CYC cycles, with no dead cycles between queued flashes.

Test Plan:
All scenarios use the overrides ON_CYC=4, OFF_CYC=3, PEND_W=2.
1. Reset:
   - Stimulus: hold rst=0 for 3 cycles, evt_pulse toggling.
   - Response: led=1, busy=0, pend_cnt=0, ovf=0 throughout; all stay at those values for 5 cycles after release with evt_pulse=0.
2. Single flash:
   - Stimulus: evt_pulse high for one cycle, sampled at edge E.
   - Response: led=0 for exactly the 4 cycles after E, then led=1. busy=1 for 7 cycles, then busy=0. pend_cnt stays 0.
3. Back-to-back queue:
   - Stimulus: three single-cycle pulses at E, E+1, E+2.
   - Response: pend_cnt reads 1 then 2 during the first flash. Three flashes of 4-on/3-off occur with no idle cycle between them. pend_cnt steps 2 to 1 to 0 at each OFF to ON transition. busy stays high for 21 cycles.
4. Overflow:
   - Stimulus: evt_pulse held high for 5 consecutive cycles starting at E.
   - Response: first event starts the flash; the next 3 fill pend_cnt to 3; the 5th gives ovf=1 for exactly one cycle. Exactly 4 flashes result.
5. Edge coincidence:
   - Stimulus (a): with pend_cnt=0, evt_pulse=1 on the final OFF cycle.
   - Response (a): ON is entered directly, busy never drops, and pend_cnt stays 0.
   - Stimulus (b): with pend_cnt=3, evt_pulse=1 on the final OFF cycle.
   - Response (b): pend_cnt stays 3 and ovf stays 0.
6. Reset mid-flash:
   - Stimulus: assert rst=0 in cycle 2 of ON with pend_cnt=2.
   - Response: led=1, busy=0, pend_cnt=0 without waiting for a clk edge. After release, no flash occurs until a new evt_pulse.
